serial_tx: RTL and testbench

Parameterised parallel-in, serial-out frame transmitter. It accepts a WIDTH-bit word through a ready/load handshake and shifts it out on a single-bit line as start bit, data bits LSB first, optional even parity, and stop bit. It is the transmitting end of the single-bit `data` line that the team's flip-flop and shift-register receive paths sample. It also replaces hand-written toggling stimulus in benches and board tests with a deterministic, frame-aligned bit source.

---
 rtl/serial_tx.sv | 161 ++++++++++++++++
 tb/tb_serial_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// A WIDTH-bit word accepted on load/ready is sent on 'out' as a frame:
// start bit (0), data bits LSB first, optional even-parity bit, and stop bit (1).
// Each bit is held for BIT_CYCLES clock cycles. All outputs are registered.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset, highest priority
//   load   in   transmit request, honoured only while ready=1
//   din    in   WIDTH-bit word, captured on the accepting edge
//   ready  out  idle and able to accept load
//   busy   out  frame in progress (complement of ready outside reset)
//   out    out  serial line, idles high
//   done   out  one-cycle pulse after the stop bit has been held
module serial_tx #(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int BIT_CYCLES = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             busy,
   output logic             out,
   output logic             done
);

   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [IW-1:0]    idx_r;
   logic [WIDTH-1:0] shreg_r;
   logic             parity_r;

   logic             bit_end_s;
   logic [WIDTH-1:0] shreg_next_s;

   // Even parity: the extra bit makes the total count of ones even.
   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction

   // Last cycle of the current serial bit, and the shift register after one shift.
   always_comb begin
      bit_end_s    = (cnt_r == CNT_LAST);
      shreg_next_s = shreg_r >> 1;
   end

   // Frame sequencer: state, counters, shift register and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r  <= IDLE;
         cnt_r    <= CNT_ZERO;
         idx_r    <= IDX_ZERO;
         shreg_r  <= '0;
         parity_r <= 1'b0;
         out      <= 1'b1;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (load) begin
                  shreg_r  <= din;
                  parity_r <= even_parity(din);
                  cnt_r    <= CNT_ZERO;
                  out      <= 1'b0;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
                  state_r  <= START;
               end else begin
                  out   <= 1'b1;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            START: begin
               if (bit_end_s) begin
                  cnt_r   <= CNT_ZERO;
                  idx_r   <= IDX_ZERO;
                  out     <= shreg_r[0];
                  state_r <= DATA;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  cnt_r <= CNT_ZERO;
                  if (idx_r == IDX_LAST) begin
                     if (PARITY_EN != 0) begin
                        out     <= parity_r;
                        state_r <= PARITY;
                     end else begin
                        out     <= 1'b1;
                        state_r <= STOP;
                     end
                  end else begin
                     // Next data bit is bit 0 of the shifted word.
                     shreg_r <= shreg_next_s;
                     out     <= shreg_next_s[0];
                     idx_r   <= idx_r + IDX_ONE;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            PARITY: begin
               if (bit_end_s) begin
                  cnt_r   <= CNT_ZERO;
                  out     <= 1'b1;
                  state_r <= STOP;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            STOP: begin
               if (bit_end_s) begin
                  cnt_r   <= CNT_ZERO;
                  out     <= 1'b1;
                  ready   <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= CNT_ZERO;
               idx_r   <= IDX_ZERO;
               out     <= 1'b1;
               ready   <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx. Two instances: A (WIDTH=8, parity, B=1)
// and B (WIDTH=8, no parity, B=3). A frame reference is built as a queue of
// expected line levels from the framing rules and compared cycle by cycle.
module tb_serial_tx;

   logic       clock;
   logic       reset;
   logic       load;
   logic [7:0] din;
   logic       sel;

   logic load_a, load_b;
   logic ready_a, busy_a, out_a, done_a;
   logic ready_b, busy_b, out_b, done_b;
   logic ready_m, busy_m, out_m, done_m;

   int tests_run;
   int tests_failed;

   assign load_a  = load & ~sel;
   assign load_b  = load & sel;
   assign ready_m = sel ? ready_b : ready_a;
   assign busy_m  = sel ? busy_b  : busy_a;
   assign out_m   = sel ? out_b   : out_a;
   assign done_m  = sel ? done_b  : done_a;

   serial_tx #(.WIDTH(8), .PARITY_EN(1), .BIT_CYCLES(1)) dut_a (
      .clock(clock), .reset(reset), .load(load_a), .din(din),
      .ready(ready_a), .busy(busy_a), .out(out_a), .done(done_a)
   );

   serial_tx #(.WIDTH(8), .PARITY_EN(0), .BIT_CYCLES(3)) dut_b (
      .clock(clock), .reset(reset), .load(load_b), .din(din),
      .ready(ready_b), .busy(busy_b), .out(out_b), .done(done_b)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checks one frame whose load was sampled at the coming posedge (edge 0).
   // poke: pulse load with 0xFF while busy. chain: hold load with next_word so
   // the following frame is accepted in the done cycle.
   task automatic check_frame(input logic [7:0] word, input bit poke, input bit chain,
                              input logic [7:0] next_word);
      logic bits[$];
      logic exp_q[$];
      int   b;
      b = sel ? 3 : 1;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(word[i]);
      if (!sel) bits.push_back(^word);
      bits.push_back(1'b1);
      foreach (bits[k]) for (int r = 0; r < b; r++) exp_q.push_back(bits[k]);

      for (int c = 1; c <= exp_q.size(); c++) begin
         @(negedge clock);
         check_value($sformatf("out w=%0h c=%0d", word, c), out_m, exp_q[c-1]);
         check_value($sformatf("busy w=%0h c=%0d", word, c), busy_m, 1'b1);
         check_value($sformatf("ready w=%0h c=%0d", word, c), ready_m, 1'b0);
         check_value($sformatf("done w=%0h c=%0d", word, c), done_m, 1'b0);
         if (c == 1) begin
            if (chain) begin
               load = 1'b1;
               din  = next_word;
            end else begin
               load = 1'b0;
               din  = 8'($urandom);
            end
         end
         if (poke && !chain) begin
            if (c == 3) begin
               load = 1'b1;
               din  = 8'hFF;
            end else if (c == 4) begin
               load = 1'b0;
            end
         end
      end
      @(negedge clock);
      check_value($sformatf("done pulse w=%0h", word), done_m, 1'b1);
      check_value($sformatf("done out w=%0h", word), out_m, 1'b1);
      check_value($sformatf("done ready w=%0h", word), ready_m, 1'b1);
      check_value($sformatf("done busy w=%0h", word), busy_m, 1'b0);
      if (!chain) begin
         @(negedge clock);
         check_value($sformatf("post done w=%0h", word), done_m, 1'b0);
         check_value($sformatf("post out w=%0h", word), out_m, 1'b1);
         check_value($sformatf("post ready w=%0h", word), ready_m, 1'b1);
         check_value($sformatf("post busy w=%0h", word), busy_m, 1'b0);
      end
   endtask

   task automatic start_frame(input logic [7:0] word);
      @(negedge clock);
      load = 1'b1;
      din  = word;
   endtask

   task automatic random_frames(input int count);
      logic [7:0] w, nw;
      bit ch, pk;
      w = 8'($urandom);
      start_frame(w);
      for (int k = 0; k < count; k++) begin
         nw = 8'($urandom);
         ch = (k < count - 1) && ($urandom_range(0, 1) == 1);
         pk = ($urandom_range(0, 1) == 1);
         check_frame(w, pk, ch, nw);
         if (k < count - 1 && !ch) begin
            load = 1'b1;
            din  = nw;
         end
         w = nw;
      end
   endtask

   logic [4:0] a5_head;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      sel   = 1'b0;
      reset = 1'b1;
      load  = 1'b1;
      din   = 8'hFF;

      // Reset held for 3 cycles with a pending load.
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check_value($sformatf("rst out_a %0d", c), out_a, 1'b1);
         check_value($sformatf("rst ready_a %0d", c), ready_a, 1'b1);
         check_value($sformatf("rst busy_a %0d", c), busy_a, 1'b0);
         check_value($sformatf("rst done_a %0d", c), done_a, 1'b0);
         check_value($sformatf("rst out_b %0d", c), out_b, 1'b1);
         check_value($sformatf("rst busy_b %0d", c), busy_b, 1'b0);
      end
      reset = 1'b0;
      load  = 1'b0;
      @(negedge clock);
      check_value("idle after rst busy", busy_a, 1'b0);
      check_value("idle after rst out", out_a, 1'b1);

      // Directed frames on instance A.
      start_frame(8'hA5);
      check_frame(8'hA5, 1'b0, 1'b0, 8'h00);
      start_frame(8'h07);
      check_frame(8'h07, 1'b1, 1'b0, 8'h00);
      start_frame(8'h3C);
      check_frame(8'h3C, 1'b0, 1'b1, 8'hC3);
      check_frame(8'hC3, 1'b0, 1'b0, 8'h00);

      // Mid-frame reset: reset sampled at edge 5 aborts the frame.
      a5_head = 5'b01010;  // line levels for cycles 1..5, first cycle in bit 4
      start_frame(8'hA5);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         if (c == 1) load = 1'b0;
         check_value($sformatf("abort out c=%0d", c), out_a, a5_head[5-c]);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_value("abort out", out_a, 1'b1);
      check_value("abort ready", ready_a, 1'b1);
      check_value("abort busy", busy_a, 1'b0);
      check_value("abort done", done_a, 1'b0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         check_value($sformatf("abort quiet done %0d", c), done_a, 1'b0);
         check_value($sformatf("abort quiet out %0d", c), out_a, 1'b1);
      end
      start_frame(8'h5A);
      check_frame(8'h5A, 1'b0, 1'b0, 8'h00);

      // Randomized frames on instance A.
      random_frames(15);

      // Instance B: bit stretching, no parity.
      sel = 1'b1;
      start_frame(8'h01);
      check_frame(8'h01, 1'b0, 1'b0, 8'h00);
      random_frames(10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
